// File: rtl/bcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seq_ctrl
// Purpose  : Two-requester arbiter in front of an 8-bit binary to 3-digit BCD
//            converter (double dabble, one bit per cycle). Optional macro
//            BCD_RR_EN switches tie-breaking from fixed PRIORITY to round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seq_ctrl #(
  parameter int PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] bin0,
  input  logic [7:0] bin1,
  output logic       ack0,
  output logic       ack1,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  sr;
  logic [11:0] scratch;
  logic [2:0]  cnt;
  logic        grant;
  logic        pick;
  logic [11:0] adj;
  logic [19:0] shifted;

`ifdef BCD_RR_EN
  logic        last;
`endif

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Winner selection; only consulted in IDLE when at least one request is up.
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
`ifdef BCD_RR_EN
      pick = ~last;
`else
      pick = (PRIORITY != 0);
`endif
    end
  end

  assign adj     = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
  assign shifted = {adj, sr} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      hundreds <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
      sr       <= 8'd0;
      scratch  <= 12'd0;
      cnt      <= 3'd0;
      grant    <= 1'b0;
`ifdef BCD_RR_EN
      last     <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant   <= pick;
            ack0    <= ~pick;
            ack1    <= pick;
            sr      <= pick ? bin1 : bin0;
            scratch <= 12'd0;
            cnt     <= 3'd0;
            busy    <= 1'b1;
            state   <= SHIFT;
`ifdef BCD_RR_EN
            last    <= pick;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          {scratch, sr} <= shifted;
          cnt           <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          // busy stays high through the done cycle; IDLE clears it next edge.
          hundreds <= scratch[11:8];
          tens     <= scratch[7:4];
          ones     <= scratch[3:0];
          done     <= 1'b1;
          done_id  <= grant;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seq_ctrl
// Purpose  : Directed self-checking bench for bcd_seq_ctrl (both tie modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_ctrl;

`ifdef BCD_RR_EN
  localparam int FIRST = 0;
  localparam int THIRD = 0;
`else
  localparam int FIRST = 1;
  localparam int THIRD = 1;
`endif
  localparam int SECOND = 1 - FIRST;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] bin0, bin1;
  logic       ack0, ack1, busy, done, done_id;
  logic [3:0] hundreds, tens, ones;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_seq_ctrl #(.PRIORITY(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .bin0     (bin0),
    .bin1     (bin1),
    .ack0     (ack0),
    .ack1     (ack1),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int id);
    return (id == 1) ? ack1 : ack0;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [7:0] b);
    if (id == 1) begin req1 = v; bin1 = b; end
    else         begin req0 = v; bin0 = b; end
  endtask

  // Waits (bounded) for any ack and checks it went to the expected requester.
  task automatic wait_ack(input int id, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(ack0 || ack1) && n < 20);
    chk({tag, "_ack"}, ack_of(id), 1);
    chk({tag, "_ack_other"}, ack_of(1 - id), 0);
  endtask

  // Called in the ack cycle; returns in the done cycle.
  task automatic finish_conv(input int id, input logic [7:0] b, input logic [11:0] exp_bcd,
                             input string tag);
    int   n;
    logic stray;
    set_req(id, 1'b0, b);
    step();
    chk({tag, "_ack_1cyc"}, ack_of(id), 0);
    chk({tag, "_busy"}, busy, 1);
    stray = ack0 | ack1;
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
      stray |= ack0 | ack1;
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_no_stray_ack"}, stray, 0);
    chk({tag, "_done_id"}, done_id, id);
    chk({tag, "_digits"}, {hundreds, tens, ones}, exp_bcd);
    chk({tag, "_busy_done"}, busy, 1);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = 8'd0; bin1 = 8'd0;
    step();
    step();
    chk("rst_outs", {ack0, ack1, busy, done, done_id, hundreds, tens, ones}, 0);
    rst = 1'b0;
    step();

    // 145 from requester 0
    set_req(0, 1'b1, 8'd145);
    wait_ack(0, "c145");
    finish_conv(0, 8'd145, 12'h145, "c145");
    step();
    chk("c145_done_pulse", done, 0);
    chk("c145_idle_busy", busy, 0);
    chk("c145_hold", {done_id, hundreds, tens, ones}, {1'b0, 12'h145});

    // Reset at the 4th shift edge aborts; held request is re-accepted
    set_req(0, 1'b1, 8'd123);
    wait_ack(0, "c123a");
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort_outs", {ack0, ack1, busy, done, done_id, hundreds, tens, ones}, 0);
    rst = 1'b0;
    step();
    chk("reack_ack0", ack0, 1);
    finish_conv(0, 8'd123, 12'h123, "c123");
    step();

    // 255 then 0 from requester 1
    set_req(1, 1'b1, 8'd255);
    wait_ack(1, "c255");
    finish_conv(1, 8'd255, 12'h255, "c255");
    step();
    set_req(1, 1'b1, 8'd0);
    wait_ack(1, "c000");
    finish_conv(1, 8'd0, 12'h000, "c000");
    step();

    // req1 raised while busy: held off until the edge ending done
    set_req(0, 1'b1, 8'd37);
    wait_ack(0, "c037");
    set_req(1, 1'b1, 8'd88);
    finish_conv(0, 8'd37, 12'h037, "c037");
    step();
    chk("pend_ack1", ack1, 1);
    finish_conv(1, 8'd88, 12'h088, "c088");
    step();

    // Tie after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 8'd99);
    set_req(1, 1'b1, 8'd200);
    wait_ack(FIRST, "tie1");
    finish_conv(FIRST, (FIRST == 1) ? 8'd200 : 8'd99,
                (FIRST == 1) ? 12'h200 : 12'h099, "tie1");
    step();
    chk("tie_loser_ack", ack_of(SECOND), 1);
    finish_conv(SECOND, (SECOND == 1) ? 8'd200 : 8'd99,
                (SECOND == 1) ? 12'h200 : 12'h099, "tie2");
    step();
    set_req(0, 1'b1, 8'd99);
    set_req(1, 1'b1, 8'd200);
    wait_ack(THIRD, "tie3");
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 The block SHALL have parameter PRIORITY, default 0, fixed-priority winner (0 or 1) when BCD_RR_EN is undefined.
REQ-002 The block SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0 and req1, input, 1 each, requester N conversion request, held until ackN.
REQ-005 The block SHALL have ports bin0 and bin1, input, 8 each, requester N binary operand, stable while reqN is high.
REQ-006 The block SHALL have ports ack0 and ack1, output, 1 each, one-cycle capture acknowledge to requester N.
REQ-007 The block SHALL have port busy, output, 1, conversion in progress.
REQ-008 The block SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-009 The block SHALL have port done_id, output, 1, requester index owning the current result.
REQ-010 The block SHALL have ports hundreds, tens and ones, output, 4 each, registered BCD digits of the last result.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-012 In IDLE with any reqN high at edge E0, the block SHALL grant one requester, load binN into an 8-bit shift register, clear the 12-bit BCD scratch register and the iteration counter, and enter SHIFT.
REQ-013 ackN SHALL be high only in the cycle following E0, for the granted requester only.
REQ-014 At each edge in SHIFT, the block SHALL add 3 to each scratch digit >= 5, then shift {scratch, shift register} left by one bit.
REQ-015 After the 8th iteration (edge E8), the FSM SHALL enter DONE.
REQ-016 At edge E9 the block SHALL load hundreds/tens/ones from scratch, drive done=1 and done_id=grant for exactly one cycle, and return to IDLE.
REQ-017 done SHALL rise exactly 9 cycles after the granted ackN rises.
REQ-018 busy SHALL be high from the cycle after E0 through the done cycle inclusive, and low in IDLE.
REQ-019 reqN high while busy SHALL be ignored, with no ack and no operand capture, until IDLE.
REQ-020 The earliest next capture SHALL be at the edge ending the done cycle (IDLE), giving 10-cycle throughput.
REQ-021 hundreds/tens/ones/done_id SHALL hold their values between done pulses.
REQ-022 Operand 255 SHALL yield 2/5/5; digits never exceed 9; hundreds never exceeds 2.
REQ-023 With req0 and req1 both high in IDLE, the winner SHALL follow REQ-028/REQ-029; the loser stays pending and is served next.

Reset
REQ-024 With rst high at an edge, the block SHALL enter IDLE, and ack0, ack1, busy, done, done_id and all digits SHALL read 0 the following cycle.
REQ-025 rst SHALL override all other inputs, including mid-SHIFT, aborting the conversion with no done pulse.
REQ-026 Reset SHALL set the round-robin last-grant register to 1, so req0 wins the first tie.
REQ-027 Requests held through reset SHALL be accepted at the first non-reset edge.

Configuration
REQ-028 With BCD_RR_EN defined, a tie SHALL go to the requester not granted last, updating last-grant on every grant.
REQ-029 With BCD_RR_EN undefined, a tie SHALL always go to requester PRIORITY, and the last-grant register SHALL be absent.

Verification
REQ-030 The bench SHALL cover: req0=1, bin0=145 -> ack0 one cycle; done 9 cycles later; digits 1/4/5; done_id=0.
REQ-031 The bench SHALL cover: req1=1, bin1=255, then bin1=0 -> digits 2/5/5, then 0/0/0; done_id=1 both times.
REQ-032 The bench SHALL cover, with BCD_RR_EN: simultaneous req0 (bin0=99) and req1 (bin1=200) after reset -> 0/9/9 id 0, then 2/0/0 id 1; then a repeated tie grants 0 next.
REQ-033 The bench SHALL cover, without BCD_RR_EN and PRIORITY=1: the same tie -> requester 1 served first, 2/0/0 id 1.
REQ-034 The bench SHALL cover: rst asserted at the 4th SHIFT edge of bin0=123 -> no done, outputs 0; the held request is re-acked and yields 1/2/3.
REQ-035 The bench SHALL cover: req1 raised while busy -> no ack1 until IDLE; ack1 at the edge ending the done cycle.
